multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum number of cycles a memory access may wait for mem_ready (range 1-255).
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  4  IR[15:12] of the held instruction.
REQ-005 zero  input  1  ALU zero flag, valid in BRANCH.
REQ-006 mem_ready  input  1  memory completes the current access when high at a rising edge.
REQ-007 mem_req  output  1  memory access request; held until accepted.
REQ-008 mem_we  output  1  write qualifier for mem_req.
REQ-009 iord  output  1  0 = address from PC; 1 = address from ALUOut.
REQ-010 ir_write, pc_write  output  1 each  load strobes for IR and PC.
REQ-011 pc_src  output  1  0 = PC+2; 1 = branch target.
REQ-012 reg_write, reg_dst, mem_to_reg  output  1 each  register-file write enable, rd/rt select, ALU/memory data select.
REQ-013 alu_src_b  output  2  00 = B, 01 = constant 2, 10 = sign-extended imm, 11 = sign-extended imm shifted left 1.
REQ-014 alu_ctl  output  3  encodings: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-015 state  output  4  current state code; error  output  1  sticky fault flag.

Function
REQ-016 State codes: RESET=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_R=8, WB_MEM=9, BRANCH=10, FAULT=15.
REQ-017 Opcodes: 0000 add, 0001 sub, 0010 and, 0011 or, 0111 slt, 0100 addi, 0101 lw, 0110 sw, 1000 beq; all others illegal.
REQ-018 Outputs are Moore-decoded from state, except pc_write and ir_write in FETCH and pc_write in BRANCH.
REQ-019 In RESET and FAULT, every output strobe is 0 and alu_ctl is 010.
REQ-020 RESET goes to FETCH on the first rising edge after resetn is high.
REQ-021 FETCH: mem_req=1, iord=0, alu_src_b=01, alu_ctl=010.
REQ-022 FETCH: ir_write and pc_write equal mem_ready; the state advances to DECODE at the edge where mem_ready=1.
REQ-023 DECODE lasts 1 cycle and computes the branch target (alu_src_b=11, alu_ctl=010).
REQ-024 DECODE next state: R-type to EXEC_R, addi to EXEC_I, lw/sw to MEM_ADDR, beq to BRANCH, illegal to FAULT.
REQ-025 EXEC_R (1 cycle): alu_src_b=00, alu_ctl per REQ-017; next state WB_R.
REQ-026 WB_R (1 cycle): reg_write=1, mem_to_reg=0; reg_dst=1 for R-type, 0 for addi; next state FETCH.
REQ-027 EXEC_I (1 cycle): alu_src_b=10, alu_ctl=010; next state WB_R.
REQ-028 MEM_ADDR (1 cycle): alu_src_b=10, alu_ctl=010; next state MEM_RD for lw, MEM_WR for sw.
REQ-029 MEM_RD/MEM_WR: mem_req=1, iord=1; mem_we=1 in MEM_WR only.
REQ-030 MEM_RD/MEM_WR exit on mem_ready: MEM_RD to WB_MEM, MEM_WR to FETCH.
REQ-031 WB_MEM (1 cycle): reg_write=1, mem_to_reg=1, reg_dst=0; next state FETCH.
REQ-032 BRANCH (1 cycle): alu_src_b=00, alu_ctl=110, pc_src=1, pc_write=zero; next state FETCH.
REQ-033 Wait counter (8 bits) clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle mem_ready=0.
REQ-034 If the wait counter reaches TIMEOUT with mem_ready still 0, the next state is FAULT; mem_ready on that same edge wins (access completes).
REQ-035 error=1 in FAULT; FAULT is exited only by reset.
REQ-036 mem_ready is ignored in states other than FETCH, MEM_RD and MEM_WR.
REQ-037 Cycles per instruction with zero-wait memory: R/addi 4, beq 3, sw 4, lw 5.

Reset
REQ-038 resetn low forces state=RESET, counter=0 and error=0 immediately, including mid-access; mem_req drops asynchronously.

Verification
REQ-039 Reset released, opcode 0000, mem_ready always 1 -> states 1,2,3,8,1; one reg_write pulse, reg_dst=1.
REQ-040 lw (0101), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_req=1, iord=1, then WB_MEM with mem_to_reg=1.
REQ-041 beq (1000) with zero=1 -> pc_write=1, pc_src=1 in BRANCH; with zero=0 -> pc_write stays 0.
REQ-042 Opcode 1111 -> DECODE then FAULT, error=1, no strobes until resetn pulses low.
REQ-043 TIMEOUT=3, mem_ready held 0 in FETCH -> FAULT after 3 cycles; a repeat run with mem_ready=1 on cycle 3 goes to DECODE instead.
REQ-044 resetn low during MEM_WR -> mem_req and mem_we go to 0 without waiting for a clock edge; after release, restart at FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface multicycle_ctrl_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic [3:0] state;
    logic       error;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_b, alu_ctl,
               state, error
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_b, alu_ctl,
               state, error
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with bounded memory wait and sticky fault state.
//
// state    | meaning
// RESET    | idle after reset, all strobes off
// FETCH    | read instruction at PC, load IR and PC+2 on mem_ready
// DECODE   | precompute branch target, dispatch on opcode
// EXEC_R   | R-type ALU operation
// EXEC_I   | addi ALU operation
// MEM_ADDR | compute lw/sw effective address
// MEM_RD   | load access, wait for mem_ready
// MEM_WR   | store access, wait for mem_ready
// WB_R     | write ALU result to register file
// WB_MEM   | write load data to register file
// BRANCH   | compare, conditionally load PC with target
// FAULT    | illegal opcode or memory timeout, left only by reset
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              resetn,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        RESET    = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        WB_R     = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        FAULT    = 4'd15
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_BEQ  = 4'b1000;

    // Counter value at which one more idle cycle means the access has timed out.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt;
    logic       in_wait;
    logic       timed_out;

    assign in_wait   = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign timed_out = !bus.mem_ready && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Counts only while parked in a wait state; any transition clears it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= 8'd0;
        end else if (in_wait && (state_d == state_q)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:    state_d = FETCH;
            FETCH: begin
                if (bus.mem_ready) begin
                    state_d = DECODE;
                end else if (timed_out) begin
                    state_d = FAULT;
                end
            end
            DECODE: begin
                case (bus.opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: state_d = EXEC_R;
                    OP_ADDI:                               state_d = EXEC_I;
                    OP_LW, OP_SW:                          state_d = MEM_ADDR;
                    OP_BEQ:                                state_d = BRANCH;
                    default:                               state_d = FAULT;
                endcase
            end
            EXEC_R:   state_d = WB_R;
            EXEC_I:   state_d = WB_R;
            MEM_ADDR: state_d = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (bus.mem_ready) begin
                    state_d = WB_MEM;
                end else if (timed_out) begin
                    state_d = FAULT;
                end
            end
            MEM_WR: begin
                if (bus.mem_ready) begin
                    state_d = FETCH;
                end else if (timed_out) begin
                    state_d = FAULT;
                end
            end
            WB_R:     state_d = FETCH;
            WB_MEM:   state_d = FETCH;
            BRANCH:   state_d = FETCH;
            FAULT:    state_d = FAULT;
            default:  state_d = FAULT;
        endcase
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_ctl    = 3'b010;
        bus.error      = 1'b0;
        bus.state      = state_q;
        case (state_q)
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            DECODE:   bus.alu_src_b = 2'b11;
            EXEC_R: begin
                case (bus.opcode)
                    OP_SUB:  bus.alu_ctl = 3'b110;
                    OP_AND:  bus.alu_ctl = 3'b000;
                    OP_OR:   bus.alu_ctl = 3'b001;
                    OP_SLT:  bus.alu_ctl = 3'b111;
                    default: bus.alu_ctl = 3'b010;
                endcase
            end
            EXEC_I:   bus.alu_src_b = 2'b10;
            MEM_ADDR: bus.alu_src_b = 2'b10;
            MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                bus.mem_we  = 1'b1;
            end
            WB_R: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = (bus.opcode != OP_ADDI);
            end
            WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            BRANCH: begin
                bus.alu_ctl  = 3'b110;
                bus.pc_src   = 1'b1;
                bus.pc_write = bus.zero;
            end
            FAULT:    bus.error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected outputs queued at drive time.
module tb_multicycle_ctrl;

    logic clock  = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    multicycle_ctrl_if bus ();
    multicycle_ctrl_if bus3 ();

    multicycle_ctrl u_dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    multicycle_ctrl #(.TIMEOUT(3)) u_dut3 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus3)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] op;
        logic       rdy;
        logic       z;
    } stim_t;

    stim_t       seq[$];
    logic [18:0] sb[$];
    logic [18:0] exp_v;
    int          checks   = 0;
    int          failures = 0;

    wire [18:0] obs_main = {bus.state, bus.error, bus.mem_req, bus.mem_we, bus.iord,
                            bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_write,
                            bus.reg_dst, bus.mem_to_reg, bus.alu_src_b, bus.alu_ctl};
    wire [18:0] obs3     = {bus3.state, bus3.error, bus3.mem_req, bus3.mem_we, bus3.iord,
                            bus3.ir_write, bus3.pc_write, bus3.pc_src, bus3.reg_write,
                            bus3.reg_dst, bus3.mem_to_reg, bus3.alu_src_b, bus3.alu_ctl};

    // Expected outputs for a given state, transcribed from the control table.
    function automatic logic [18:0] model(input logic [3:0] st, input logic [3:0] op,
                                          input logic z, input logic rdy);
        logic err, req, we, iord, irw, pcw, pcs, rw, rd, m2r;
        logic [1:0] srcb;
        logic [2:0] alu;
        {err, req, we, iord, irw, pcw, pcs, rw, rd, m2r} = '0;
        srcb = 2'b00;
        alu  = 3'b010;
        case (st)
            4'd1: begin req = 1'b1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            4'd2: srcb = 2'b11;
            4'd3: begin
                case (op)
                    4'b0001: alu = 3'b110;
                    4'b0010: alu = 3'b000;
                    4'b0011: alu = 3'b001;
                    4'b0111: alu = 3'b111;
                    default: alu = 3'b010;
                endcase
            end
            4'd4, 4'd5: srcb = 2'b10;
            4'd6: begin req = 1'b1; iord = 1'b1; end
            4'd7: begin req = 1'b1; iord = 1'b1; we = 1'b1; end
            4'd8: begin rw = 1'b1; rd = (op != 4'b0100); end
            4'd9: begin rw = 1'b1; m2r = 1'b1; end
            4'd10: begin alu = 3'b110; pcs = 1'b1; pcw = z; end
            4'd15: err = 1'b1;
            default: ;
        endcase
        return {st, err, req, we, iord, irw, pcw, pcs, rw, rd, m2r, srcb, alu};
    endfunction

    task automatic add(input logic [3:0] st, input logic [3:0] op, input logic rdy, input logic z);
        stim_t s;
        s.st = st; s.op = op; s.rdy = rdy; s.z = z;
        seq.push_back(s);
    endtask

    task automatic drive(input stim_t s);
        bus.opcode     = s.op;
        bus.zero       = s.z;
        bus.mem_ready  = s.rdy;
        bus3.opcode    = s.op;
        bus3.zero      = s.z;
        bus3.mem_ready = s.rdy;
        sb.push_back(model(s.st, s.op, s.z, s.rdy));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus.opcode = 4'd0;  bus.zero = 1'b0;  bus.mem_ready = 1'b0;
        bus3.opcode = 4'd0; bus3.zero = 1'b0; bus3.mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        seq.delete();
        @(negedge clock);
        resetn = 1'b0;
        add(4'd0, 4'd0, 1'b1, 1'b1);
        add(4'd0, 4'd0, 1'b1, 1'b1);
        foreach (seq[i]) begin
            drive(seq[i]);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (obs_main !== exp_v) begin
                failures++;
                $display("FAIL reset_hold[%0d] got=%h want=%h", i, obs_main, exp_v);
            end
            @(negedge clock);
        end
        resetn = 1'b1;
        seq.delete();
        add(4'd0, 4'd0, 1'b0, 1'b0);
        add(4'd1, 4'd0, 1'b0, 1'b0);
        foreach (seq[i]) begin
            drive(seq[i]);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (obs_main !== exp_v) begin
                failures++;
                $display("FAIL reset_release[%0d] got=%h want=%h", i, obs_main, exp_v);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_r_type();
        logic [3:0] ops[6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b0100};
        foreach (ops[k]) begin
            do_reset();
            seq.delete();
            add(4'd0, ops[k], 1'b1, 1'b0);
            add(4'd1, ops[k], 1'b1, 1'b0);
            add(4'd2, ops[k], 1'b1, 1'b0);
            add((ops[k] == 4'b0100) ? 4'd4 : 4'd3, ops[k], 1'b1, 1'b0);
            add(4'd8, ops[k], 1'b1, 1'b0);
            add(4'd1, ops[k], 1'b0, 1'b0);
            foreach (seq[i]) begin
                drive(seq[i]);
                #1;
                exp_v = sb.pop_front();
                checks++;
                if (obs_main !== exp_v) begin
                    failures++;
                    $display("FAIL alu_op%0d[%0d] got=%h want=%h", k, i, obs_main, exp_v);
                end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_mem();
        do_reset();
        seq.delete();
        add(4'd0, 4'b0101, 1'b1, 1'b0);
        add(4'd1, 4'b0101, 1'b1, 1'b0);
        add(4'd2, 4'b0101, 1'b0, 1'b0);
        add(4'd5, 4'b0101, 1'b1, 1'b0);
        add(4'd6, 4'b0101, 1'b0, 1'b0);
        add(4'd6, 4'b0101, 1'b0, 1'b0);
        add(4'd6, 4'b0101, 1'b0, 1'b0);
        add(4'd6, 4'b0101, 1'b1, 1'b0);
        add(4'd9, 4'b0101, 1'b1, 1'b0);
        add(4'd1, 4'b0110, 1'b1, 1'b0);
        add(4'd2, 4'b0110, 1'b1, 1'b0);
        add(4'd5, 4'b0110, 1'b0, 1'b0);
        add(4'd7, 4'b0110, 1'b1, 1'b0);
        add(4'd1, 4'b0110, 1'b0, 1'b0);
        foreach (seq[i]) begin
            drive(seq[i]);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (obs_main !== exp_v) begin
                failures++;
                $display("FAIL lw_sw[%0d] got=%h want=%h", i, obs_main, exp_v);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_beq();
        for (int zz = 1; zz >= 0; zz--) begin
            do_reset();
            seq.delete();
            add(4'd0, 4'b1000, 1'b1, 1'(zz));
            add(4'd1, 4'b1000, 1'b1, 1'(zz));
            add(4'd2, 4'b1000, 1'b1, 1'(zz));
            add(4'd10, 4'b1000, 1'b1, 1'(zz));
            add(4'd1, 4'b1000, 1'b0, 1'(zz));
            foreach (seq[i]) begin
                drive(seq[i]);
                #1;
                exp_v = sb.pop_front();
                checks++;
                if (obs_main !== exp_v) begin
                    failures++;
                    $display("FAIL beq_z%0d[%0d] got=%h want=%h", zz, i, obs_main, exp_v);
                end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] ops[2] = '{4'b1111, 4'b1001};
        foreach (ops[k]) begin
            do_reset();
            seq.delete();
            add(4'd0, ops[k], 1'b1, 1'b1);
            add(4'd1, ops[k], 1'b1, 1'b1);
            add(4'd2, ops[k], 1'b1, 1'b1);
            add(4'd15, ops[k], 1'b1, 1'b1);
            add(4'd15, 4'b0000, 1'b1, 1'b1);
            add(4'd15, 4'b0000, 1'b0, 1'b1);
            foreach (seq[i]) begin
                drive(seq[i]);
                #1;
                exp_v = sb.pop_front();
                checks++;
                if (obs_main !== exp_v) begin
                    failures++;
                    $display("FAIL illegal%0d[%0d] got=%h want=%h", k, i, obs_main, exp_v);
                end
                @(negedge clock);
            end
        end
        do_reset();
        seq.delete();
        add(4'd0, 4'b0000, 1'b1, 1'b0);
        add(4'd1, 4'b0000, 1'b1, 1'b0);
        foreach (seq[i]) begin
            drive(seq[i]);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (obs_main !== exp_v) begin
                failures++;
                $display("FAIL fault_clear[%0d] got=%h want=%h", i, obs_main, exp_v);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_timeout();
        // TIMEOUT=3 instance: fault after three idle FETCH cycles, or decode if ready on the third.
        for (int run = 0; run < 2; run++) begin
            do_reset();
            seq.delete();
            add(4'd0, 4'b0000, 1'b0, 1'b0);
            add(4'd1, 4'b0000, 1'b0, 1'b0);
            add(4'd1, 4'b0000, 1'b0, 1'b0);
            add(4'd1, 4'b0000, 1'(run), 1'b0);
            add(run ? 4'd2 : 4'd15, 4'b0000, 1'b0, 1'b0);
            add(run ? 4'd3 : 4'd15, 4'b0000, 1'b0, 1'b0);
            foreach (seq[i]) begin
                drive(seq[i]);
                #1;
                exp_v = sb.pop_front();
                checks++;
                if (obs3 !== exp_v) begin
                    failures++;
                    $display("FAIL timeout3_run%0d[%0d] got=%h want=%h", run, i, obs3, exp_v);
                end
                @(negedge clock);
            end
        end
        // Default instance in MEM_RD: 14 idle cycles then ready completes, 15 idle cycles faults.
        for (int run = 0; run < 2; run++) begin
            do_reset();
            seq.delete();
            add(4'd0, 4'b0101, 1'b1, 1'b0);
            add(4'd1, 4'b0101, 1'b1, 1'b0);
            add(4'd2, 4'b0101, 1'b1, 1'b0);
            add(4'd5, 4'b0101, 1'b1, 1'b0);
            for (int c = 0; c < 14; c++) add(4'd6, 4'b0101, 1'b0, 1'b0);
            add(4'd6, 4'b0101, run ? 1'b0 : 1'b1, 1'b0);
            add(run ? 4'd15 : 4'd9, 4'b0101, 1'b1, 1'b0);
            foreach (seq[i]) begin
                drive(seq[i]);
                #1;
                exp_v = sb.pop_front();
                checks++;
                if (obs_main !== exp_v) begin
                    failures++;
                    $display("FAIL timeout15_run%0d[%0d] got=%h want=%h", run, i, obs_main, exp_v);
                end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        seq.delete();
        add(4'd0, 4'b0110, 1'b1, 1'b0);
        add(4'd1, 4'b0110, 1'b1, 1'b0);
        add(4'd2, 4'b0110, 1'b1, 1'b0);
        add(4'd5, 4'b0110, 1'b1, 1'b0);
        add(4'd7, 4'b0110, 1'b0, 1'b0);
        foreach (seq[i]) begin
            drive(seq[i]);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (obs_main !== exp_v) begin
                failures++;
                $display("FAIL async_pre[%0d] got=%h want=%h", i, obs_main, exp_v);
            end
            if (i != seq.size() - 1) @(negedge clock);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.state} !== 6'b00_0000) begin
            failures++;
            $display("FAIL async_drop got=%b want=000000", {bus.mem_req, bus.mem_we, bus.state});
        end
        @(negedge clock);
        resetn = 1'b1;
        seq.delete();
        add(4'd0, 4'b0000, 1'b1, 1'b0);
        add(4'd1, 4'b0000, 1'b1, 1'b0);
        add(4'd2, 4'b0000, 1'b1, 1'b0);
        foreach (seq[i]) begin
            drive(seq[i]);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (obs_main !== exp_v) begin
                failures++;
                $display("FAIL async_restart[%0d] got=%h want=%h", i, obs_main, exp_v);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        seq.delete();
        add(4'd0, 4'b0000, 1'b1, 1'b0);
        add(4'd1, 4'b0000, 1'b1, 1'b0);
        add(4'd2, 4'b0000, 1'b1, 1'b0);
        add(4'd3, 4'b0000, 1'b1, 1'b0);
        add(4'd8, 4'b0000, 1'b1, 1'b0);
        add(4'd1, 4'b0101, 1'b1, 1'b0);
        add(4'd2, 4'b0101, 1'b1, 1'b0);
        add(4'd5, 4'b0101, 1'b1, 1'b0);
        add(4'd6, 4'b0101, 1'b1, 1'b0);
        add(4'd9, 4'b0101, 1'b1, 1'b0);
        add(4'd1, 4'b1000, 1'b1, 1'b1);
        add(4'd2, 4'b1000, 1'b1, 1'b1);
        add(4'd10, 4'b1000, 1'b1, 1'b1);
        add(4'd1, 4'b0110, 1'b1, 1'b0);
        add(4'd2, 4'b0110, 1'b1, 1'b0);
        add(4'd5, 4'b0110, 1'b1, 1'b0);
        add(4'd7, 4'b0110, 1'b1, 1'b0);
        add(4'd1, 4'b0011, 1'b0, 1'b0);
        foreach (seq[i]) begin
            drive(seq[i]);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (obs_main !== exp_v) begin
                failures++;
                $display("FAIL back_to_back[%0d] got=%h want=%h", i, obs_main, exp_v);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_r_type();
        test_mem();
        test_beq();
        test_illegal();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
